// File: rtl/heart_monitor.sv
// heart_monitor
//   Receive-side checker for a cycling 4-bit heartbeat count (0..CNT_MAX).
//   It hunts for a 0 and then tracks successors. After LOCK_BEATS correct
//   beats it declares lock. A sequence error or stall while locked moves it
//   to a sticky FAULT state that only clear_in or rst_in can leave.
//
//   Optional feature macro: HEART_MON_STALL_EN
//     defined   -> stall counter and stall detection are built
//     undefined -> no stall counter, stall_out stays 0, gaps are legal
//
// Ports
//   clk_in        system clock
//   rst_in        synchronous active-high reset (overrides everything)
//   sample_in     heart_cnt_in is valid this cycle
//   heart_cnt_in  4-bit heartbeat count under test
//   clear_in      clears fault/error count, restarts acquisition; wins
//                 over a sample in the same cycle
//   locked_out    high while LOCKED
//   fault_out     high while FAULT
//   stall_out     sticky stall indication
//   wrap_out      one-cycle pulse per correctly received 0 while LOCKED
//   err_cnt_out   saturating sequence-error count
module heart_monitor #(
  parameter int CNT_MAX     = 7,
  parameter int LOCK_BEATS  = 8,
  parameter int STALL_LIMIT = 16,
  parameter int ERR_W       = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             sample_in,
  input  logic [3:0]       heart_cnt_in,
  input  logic             clear_in,
  output logic             locked_out,
  output logic             fault_out,
  output logic             stall_out,
  output logic             wrap_out,
  output logic [ERR_W-1:0] err_cnt_out
);

  localparam logic [3:0]  CNT_L   = 4'(CNT_MAX);
  localparam logic [7:0]  LOCK_L  = 8'(LOCK_BEATS);
  localparam logic [15:0] STALL_L = 16'(STALL_LIMIT);

  typedef enum logic [1:0] {SEEK, TRACK, LOCKED, FAULT} state_e;

  state_e           state_q;
  logic [3:0]       prev_q;
  logic [7:0]       good_q;
  logic [ERR_W-1:0] err_q;
  logic             locked_q;
  logic             fault_q;
  logic             stall_q;
  logic             wrap_q;

  logic [3:0]       expected_d;
  logic             match_d;
  logic [7:0]       good_d;
  logic [ERR_W-1:0] err_d;
  logic             stall_hit_d;

  always_comb begin
    expected_d = (prev_q == CNT_L) ? 4'd0 : prev_q + 4'd1;
    // A prev value above CNT_MAX (loaded from a bad sample in FAULT) can
    // yield an out-of-range expected value, so range is checked separately.
    match_d    = (heart_cnt_in <= CNT_L) && (heart_cnt_in == expected_d);
    good_d     = good_q + 8'd1;
    err_d      = (&err_q) ? err_q : err_q + 1'b1;
  end

`ifdef HEART_MON_STALL_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + 16'd1;
    stall_hit_d = !sample_in && (state_q == TRACK || state_q == LOCKED) &&
                  (stall_cnt_d == STALL_L);
  end

  // Counts idle cycles only while a stream is expected; held at 0 otherwise.
  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in || sample_in || stall_hit_d ||
        state_q == SEEK || state_q == FAULT) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`else
  // No stall detection in this build. STALL_LIMIT is at least 2, so this
  // is constant 0 and the stall branch below folds away.
  assign stall_hit_d = (STALL_L == 16'd0);
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= SEEK;
      prev_q   <= 4'd0;
      good_q   <= 8'd0;
      err_q    <= '0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
      stall_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else if (clear_in) begin
      // Any sample in this cycle is discarded.
      state_q  <= SEEK;
      good_q   <= 8'd0;
      err_q    <= '0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
      stall_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (sample_in) begin
        case (state_q)
          SEEK: begin
            if (heart_cnt_in == 4'd0) begin
              prev_q  <= 4'd0;
              good_q  <= 8'd0;
              state_q <= TRACK;
            end
          end
          TRACK: begin
            prev_q <= heart_cnt_in;
            if (!match_d) begin
              state_q <= SEEK;
            end else begin
              good_q <= good_d;
              if (good_d == LOCK_L) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end
          end
          LOCKED: begin
            prev_q <= heart_cnt_in;
            if (!match_d) begin
              err_q    <= err_d;
              state_q  <= FAULT;
              locked_q <= 1'b0;
              fault_q  <= 1'b1;
            end else if (heart_cnt_in == 4'd0) begin
              wrap_q <= 1'b1;
            end
          end
          default: begin  // FAULT: only mismatches are counted
            prev_q <= heart_cnt_in;
            if (!match_d) begin
              err_q <= err_d;
            end
          end
        endcase
      end else if (stall_hit_d) begin
        stall_q <= 1'b1;
        if (state_q == TRACK) begin
          state_q <= SEEK;
        end else begin
          state_q  <= FAULT;
          locked_q <= 1'b0;
          fault_q  <= 1'b1;
          err_q    <= err_d;
        end
      end
    end
  end

  assign locked_out  = locked_q;
  assign fault_out   = fault_q;
  assign stall_out   = stall_q;
  assign wrap_out    = wrap_q;
  assign err_cnt_out = err_q;

endmodule
